video_timing_stream: RTL

- Parametrised successor to the camera-to-LCD timing/data bridge.
- Buffers an incoming pixel stream in an internal synchronous FIFO and generates programmable hs/vs/de timing.
- Re-aligns output timing to every input frame start, and only starts a frame after a prefill threshold is reached.
- Detects underflow and overflow, substituting a blank colour when the buffer runs dry; sits between the DVP capture/FIFO stage and the RGB LCD/HDMI output.

---
 rtl/vts_pkg.sv | 34 +++
 rtl/vts_sync_fifo.sv | 69 ++++++
 rtl/video_timing_stream.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vts_pkg.sv
// Shared types, default timing and width helpers for the video timing stream bridge.
package vts_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } vts_state_e;

  function automatic int vts_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic int vts_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_FIFO_DEPTH = 1024;

  localparam int DEF_H_TOTAL = vts_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = vts_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_H_CNT_W = vts_width(DEF_H_TOTAL);
  localparam int DEF_V_CNT_W = vts_width(DEF_V_TOTAL);
  localparam int DEF_LEVEL_W = vts_width(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/vts_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; head word is visible on rd_data
// whenever empty is low.
module vts_sync_fifo
  import vts_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                          video_clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = vts_width(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_C = LW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  // Accept/pop qualification: a full FIFO still takes a write when the head leaves this cycle.
  always_comb begin
    rd_ok_s = rd_en & ~empty;
    wr_ok_s = wr_en & (~full | rd_ok_s);
  end

  // Pointer and occupancy bookkeeping; flush wins over any same-cycle traffic.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge video_clk) begin
    if (wr_ok_s & ~flush) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (level_r == DEPTH_C);
  assign empty   = (level_r == {LW{1'b0}});
  assign level   = level_r;

endmodule

// File: rtl/video_timing_stream.sv
// Pixel-stream to LCD timing bridge: buffers input words, prefills, then plays them out
// under programmable hs/vs/de timing re-aligned to every input frame start.
module video_timing_stream
  import vts_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PREFILL    = 256,
  parameter logic [DATA_WIDTH-1:0] BLANK_DATA = {DATA_WIDTH{1'b0}}
) (
  input  logic                        video_clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        in_vs,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic [DATA_WIDTH-1:0]       vout_data,
  output logic                        locked,
  output logic                        underflow,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int H_TOTAL = vts_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vts_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW  = vts_width(H_TOTAL);
  localparam int VW  = vts_width(V_TOTAL);
  localparam int HCW = HW + 1;
  localparam int VCW = VW + 1;
  localparam int LW  = vts_width(FIFO_DEPTH) + 1;

  // One extra bit keeps range ends such as H_TOTAL representable.
  localparam logic [HCW-1:0] H_ACT_C     = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SYNC_LO_C = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SYNC_HI_C = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]  H_LAST_C    = HW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_C     = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SYNC_LO_C = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SYNC_HI_C = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]  V_LAST_C    = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0]  PREFILL_C   = LW'(PREFILL);

  generate
    if (PREFILL < 32'sd1 || PREFILL > FIFO_DEPTH) begin : g_bad_prefill
      $error("video_timing_stream: PREFILL must lie in 1..FIFO_DEPTH");
    end
    if (FIFO_DEPTH < 32'sd4 || (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0) begin : g_bad_depth
      $error("video_timing_stream: FIFO_DEPTH must be a power of two >= 4");
    end
    if (DATA_WIDTH < 32'sd1 || H_ACTIVE < 32'sd1 || H_SYNC < 32'sd1 ||
        V_ACTIVE < 32'sd1 || V_SYNC < 32'sd1 || H_FP < 32'sd0 || H_BP < 32'sd0 ||
        V_FP < 32'sd0 || V_BP < 32'sd0) begin : g_bad_timing
      $error("video_timing_stream: active and sync widths must be nonzero");
    end
  endgenerate

  vts_state_e            state_r;
  logic                  in_vs_q_r;
  logic [HW-1:0]         h_cnt_r;
  logic [VW-1:0]         v_cnt_r;
  logic                  hs_r, vs_r, de_r, locked_r, underflow_r, overflow_r;
  logic [DATA_WIDTH-1:0] data_r;

  logic                  vs_rise_s, run_s, out_en_s;
  logic [HCW-1:0]        h_ext_s;
  logic [VCW-1:0]        v_ext_s;
  logic                  de_i_s, hs_i_s, vs_i_s;
  logic                  pop_s, wr_req_s, wr_drop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic [LW-1:0]         fifo_level_s;

  // Frame-edge detect, raw timing decode and FIFO traffic qualification.
  always_comb begin
    vs_rise_s = in_vs & ~in_vs_q_r;
    run_s     = (state_r == ST_RUN);
    out_en_s  = run_s & ~vs_rise_s;
    h_ext_s   = {1'b0, h_cnt_r};
    v_ext_s   = {1'b0, v_cnt_r};
    de_i_s    = (h_ext_s < H_ACT_C) & (v_ext_s < V_ACT_C);
    hs_i_s    = (h_ext_s >= H_SYNC_LO_C) & (h_ext_s < H_SYNC_HI_C);
    vs_i_s    = (v_ext_s >= V_SYNC_LO_C) & (v_ext_s < V_SYNC_HI_C);
    pop_s     = out_en_s & de_i_s & ~fifo_empty_s;
    wr_req_s  = in_valid & (state_r != ST_IDLE) & ~vs_rise_s;
    wr_drop_s = wr_req_s & fifo_full_s & ~pop_s;
  end

  vts_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .flush     (vs_rise_s),
    .wr_en     (wr_req_s),
    .wr_data   (in_data),
    .rd_en     (pop_s),
    .rd_data   (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // Input frame sync history.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) in_vs_q_r <= 1'b0;
    else        in_vs_q_r <= in_vs;
  end

  // Control FSM with raster counters; any input frame edge restarts prefill.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      h_cnt_r  <= {HW{1'b0}};
      v_cnt_r  <= {VW{1'b0}};
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          h_cnt_r  <= {HW{1'b0}};
          v_cnt_r  <= {VW{1'b0}};
          locked_r <= 1'b0;
          if (vs_rise_s) state_r <= ST_PREFILL;
        end
        ST_PREFILL: begin
          h_cnt_r <= {HW{1'b0}};
          v_cnt_r <= {VW{1'b0}};
          if (!vs_rise_s && fifo_level_s >= PREFILL_C) begin
            state_r  <= ST_RUN;
            locked_r <= 1'b1;
          end else begin
            locked_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (vs_rise_s) begin
            state_r  <= ST_PREFILL;
            locked_r <= 1'b0;
            h_cnt_r  <= {HW{1'b0}};
            v_cnt_r  <= {VW{1'b0}};
          end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= (v_cnt_r == V_LAST_C) ? {VW{1'b0}} : v_cnt_r + VW'(1'b1);
          end else begin
            h_cnt_r <= h_cnt_r + HW'(1'b1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          locked_r <= 1'b0;
          h_cnt_r  <= {HW{1'b0}};
          v_cnt_r  <= {VW{1'b0}};
        end
      endcase
    end
  end

  // Registered video outputs; a starved active cycle emits the blank colour.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r        <= ~HS_POL;
      vs_r        <= ~VS_POL;
      de_r        <= 1'b0;
      data_r      <= {DATA_WIDTH{1'b0}};
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      hs_r        <= (out_en_s & hs_i_s) ? HS_POL : ~HS_POL;
      vs_r        <= (out_en_s & vs_i_s) ? VS_POL : ~VS_POL;
      de_r        <= out_en_s & de_i_s;
      underflow_r <= out_en_s & de_i_s & fifo_empty_s;
      overflow_r  <= wr_drop_s;
      if (pop_s)                 data_r <= fifo_head_s;
      else if (out_en_s & de_i_s) data_r <= BLANK_DATA;
    end
  end

  assign hs         = hs_r;
  assign vs         = vs_r;
  assign de         = de_r;
  assign vout_data  = data_r;
  assign locked     = locked_r;
  assign underflow  = underflow_r;
  assign overflow   = overflow_r;
  assign fifo_level = fifo_level_s;

endmodule
